// File: rtl/game_sequencer.sv
// Round controller for the Whac-A-Mole game: sequences the countdown timer,
// runs the "get ready" pre-count and publishes registered game status.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; timer held in reset
// READY     | pre-round countdown, one ready_count step per second
// PLAYING   | timer running, moles spawn and hits score
// PAUSED    | timer frozen, play suspended
// GAME_OVER | timer expired, display holds 0.000 until the next start
module game_sequencer #(
    parameter int GAME_LENGTH_SECONDS = 20,
    parameter int CLKS_PER_MS         = 50000,
    parameter int READY_SECONDS       = 3,
    parameter int MS_W                = $clog2(1000),
    localparam int SEC_W              = $clog2(GAME_LENGTH_SECONDS),
    localparam int RDY_W              = $clog2(READY_SECONDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             pause_pulse,
    input  logic [SEC_W-1:0] count_down_seconds,
    input  logic [MS_W-1:0]  count_down_milliseconds,
    output logic             timer_rst,
    output logic             timer_enable,
    output logic [RDY_W-1:0] ready_count,
    output logic             game_active,
    output logic             paused,
    output logic             game_over,
    output logic [7:0]       round_count,
    output logic [2:0]       state
);

    localparam int CLKS_PER_SEC = CLKS_PER_MS * 1000;
    localparam int PRE_W        = $clog2(CLKS_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_PLAYING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   prescaler, pre_d;
    logic [RDY_W-1:0]   ready_d;
    logic [7:0]         round_d;
    logic               sec_tick, expiry;
    logic               timer_rst_d, enable_d, active_d, paused_d, over_d;

    assign state = state_q;

    // Next state plus the registered outputs that belong to it, so outputs
    // change on the same edge as the state register.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_count;
        round_d  = round_count;
        pre_d    = '0;
        sec_tick = (state_q == S_READY) && (prescaler == PRE_MAX);
        expiry   = (count_down_seconds == '0) && (count_down_milliseconds == '0);

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    state_d = S_READY;
                    ready_d = RDY_W'(READY_SECONDS);
                end
            end
            S_READY: begin
                if (start_pulse) begin
                    state_d = S_IDLE;
                end else begin
                    pre_d = sec_tick ? '0 : prescaler + 1'b1;
                    if (sec_tick) begin
                        ready_d = ready_count - 1'b1;
                        if (ready_count == RDY_W'(1)) state_d = S_PLAYING;
                    end
                end
            end
            S_PLAYING: begin
                if (expiry) begin
                    state_d = S_GAME_OVER;
                    if (round_count != 8'hFF) round_d = round_count + 8'd1;
                end else if (start_pulse) begin
                    state_d = S_IDLE;
                end else if (pause_pulse) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (start_pulse)      state_d = S_IDLE;
                else if (pause_pulse) state_d = S_PLAYING;
            end
            S_GAME_OVER: begin
                if (start_pulse) begin
                    state_d = S_READY;
                    ready_d = RDY_W'(READY_SECONDS);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != S_READY) ready_d = '0;

        // Timer reset is held in IDLE and pulsed for one cycle on READY entry
        // so that a fresh round always starts from a reloaded timer.
        timer_rst_d = (state_d == S_IDLE) || ((state_d == S_READY) && (state_q != S_READY));
        enable_d    = (state_d == S_PLAYING);
        active_d    = (state_d == S_PLAYING);
        paused_d    = (state_d == S_PAUSED);
        over_d      = (state_d == S_GAME_OVER);
    end

    // State, prescaler and all status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prescaler    <= '0;
            timer_rst    <= 1'b1;
            timer_enable <= 1'b0;
            ready_count  <= '0;
            game_active  <= 1'b0;
            paused       <= 1'b0;
            game_over    <= 1'b0;
            round_count  <= 8'd0;
        end else begin
            state_q      <= state_d;
            prescaler    <= pre_d;
            timer_rst    <= timer_rst_d;
            timer_enable <= enable_d;
            ready_count  <= ready_d;
            game_active  <= active_d;
            paused       <= paused_d;
            game_over    <= over_d;
            round_count  <= round_d;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a timer emulator, a behavioural
// round model compared every cycle, and directed literal checks.
module tb_game_sequencer;

    localparam int GAME_LEN    = 3;
    localparam int CLKS_PER_MS = 2;
    localparam int READY_SEC   = 2;
    localparam int MS_W        = $clog2(1000);
    localparam int SEC_W       = $clog2(GAME_LEN);
    localparam int RDY_W       = $clog2(READY_SEC + 1);
    localparam int SEC_CLK     = CLKS_PER_MS * 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_pulse = 1'b0;
    logic             pause_pulse = 1'b0;
    logic [SEC_W-1:0] count_down_seconds = '0;
    logic [MS_W-1:0]  count_down_milliseconds = '0;
    logic             timer_rst, timer_enable, game_active, paused, game_over;
    logic [RDY_W-1:0] ready_count;
    logic [7:0]       round_count;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;
    bit force_timer = 1'b0;
    int sub = 0;

    // Behavioural model: mode 0..4, cycles spent in READY, rounds completed
    int m_mode = 0;
    int m_elapsed = 0;
    int m_rounds = 0;
    bit m_exp;

    game_sequencer #(
        .GAME_LENGTH_SECONDS(GAME_LEN),
        .CLKS_PER_MS(CLKS_PER_MS),
        .READY_SECONDS(READY_SEC),
        .MS_W(MS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_pulse(start_pulse),
        .pause_pulse(pause_pulse),
        .count_down_seconds(count_down_seconds),
        .count_down_milliseconds(count_down_milliseconds),
        .timer_rst(timer_rst),
        .timer_enable(timer_enable),
        .ready_count(ready_count),
        .game_active(game_active),
        .paused(paused),
        .game_over(game_over),
        .round_count(round_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse(input bit s, input bit p);
        start_pulse = s;
        pause_pulse = p;
        @(negedge clk);
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
    endtask

    // Countdown timer emulation driven by the DUT's timer_rst/timer_enable.
    always @(negedge clk) begin
        if (!force_timer) begin
            if (timer_rst) begin
                count_down_seconds      = SEC_W'(GAME_LEN);
                count_down_milliseconds = '0;
                sub = 0;
            end else if (timer_enable &&
                         !(count_down_seconds == 0 && count_down_milliseconds == 0)) begin
                sub++;
                if (sub == CLKS_PER_MS) begin
                    sub = 0;
                    if (count_down_milliseconds == 0) begin
                        count_down_milliseconds = MS_W'(999);
                        count_down_seconds      = count_down_seconds - 1'b1;
                    end else begin
                        count_down_milliseconds = count_down_milliseconds - 1'b1;
                    end
                end
            end
        end
    end

    // Reference round model stepped on the same edge the DUT samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_elapsed = 0; m_rounds = 0;
        end else begin
            m_exp = (count_down_seconds == 0) && (count_down_milliseconds == 0);
            case (m_mode)
                0: if (start_pulse) begin m_mode = 1; m_elapsed = 0; end
                1: if (start_pulse) m_mode = 0;
                   else begin
                       m_elapsed++;
                       if (m_elapsed == READY_SEC * SEC_CLK) m_mode = 2;
                   end
                2: if (m_exp) begin
                       m_mode = 4;
                       if (m_rounds < 255) m_rounds++;
                   end else if (start_pulse) m_mode = 0;
                   else if (pause_pulse) m_mode = 3;
                3: if (start_pulse) m_mode = 0;
                   else if (pause_pulse) m_mode = 2;
                4: if (start_pulse) begin m_mode = 1; m_elapsed = 0; end
                default: m_mode = 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("state", int'(state), m_mode);
        chk("timer_rst", int'(timer_rst), (m_mode == 0 || (m_mode == 1 && m_elapsed == 0)) ? 1 : 0);
        chk("timer_enable", int'(timer_enable), (m_mode == 2) ? 1 : 0);
        chk("ready_count", int'(ready_count), (m_mode == 1) ? READY_SEC - m_elapsed / SEC_CLK : 0);
        chk("game_active", int'(game_active), (m_mode == 2) ? 1 : 0);
        chk("paused", int'(paused), (m_mode == 3) ? 1 : 0);
        chk("game_over", int'(game_over), (m_mode == 4) ? 1 : 0);
        chk("round_count", int'(round_count), m_rounds);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, fm, n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("t1_state", int'(state), 0);
        chk("t1_trst", int'(timer_rst), 1);
        chk("t1_en", int'(timer_enable), 0);
        chk("t1_rounds", int'(round_count), 0);

        pulse(1'b1, 1'b0);
        chk("t1_ready_state", int'(state), 1);
        chk("t1_ready_cnt", int'(ready_count), 2);
        chk("t1_trst_pulse", int'(timer_rst), 1);
        @(negedge clk);
        chk("t1_trst_low", int'(timer_rst), 0);

        repeat (1998) @(negedge clk);
        chk("t2_before_tick", int'(ready_count), 2);
        @(negedge clk);
        chk("t2_first_tick", int'(ready_count), 1);
        repeat (1999) @(negedge clk);
        chk("t2_still_ready", int'(state), 1);
        @(negedge clk);
        chk("t2_playing", int'(state), 2);
        chk("t2_ready_zero", int'(ready_count), 0);
        chk("t2_en", int'(timer_enable), 1);
        chk("t2_active", int'(game_active), 1);

        n = 0;
        while (count_down_seconds != 2 && n < 3000) begin @(negedge clk); n++; end
        chk("t3_sec2", int'(count_down_seconds), 2);
        pulse(1'b0, 1'b1);
        chk("t3_paused_state", int'(state), 3);
        chk("t3_paused_en", int'(timer_enable), 0);
        chk("t3_paused_flag", int'(paused), 1);
        fs = int'(count_down_seconds);
        fm = int'(count_down_milliseconds);
        repeat (5000) @(negedge clk);
        chk("t3_frozen", int'(count_down_seconds) * 1000 + int'(count_down_milliseconds), fs * 1000 + fm);
        pulse(1'b0, 1'b1);
        chk("t3_resume_state", int'(state), 2);
        repeat (10) @(negedge clk);
        chk("t3_resumed", (int'(count_down_seconds) * 1000 + int'(count_down_milliseconds) < fs * 1000 + fm) ? 1 : 0, 1);

        n = 0;
        while (!(count_down_seconds == 0 && count_down_milliseconds == 0) && n < 8000) begin
            @(negedge clk); #1; n++;
        end
        chk("t4_expiry_seen", (n < 8000) ? 1 : 0, 1);
        @(negedge clk);
        chk("t4_over_state", int'(state), 4);
        chk("t4_over_flag", int'(game_over), 1);
        chk("t4_over_en", int'(timer_enable), 0);
        chk("t4_rounds", int'(round_count), 1);
        pulse(1'b1, 1'b0);
        chk("t4_restart", int'(state), 1);
        chk("t4_trst", int'(timer_rst), 1);
        @(negedge clk);
        chk("t4_trst_low", int'(timer_rst), 0);
        chk("t4_reload_sec", int'(count_down_seconds), 3);
        chk("t4_reload_ms", int'(count_down_milliseconds), 0);

        repeat (3999) @(negedge clk);
        chk("t5_playing", int'(state), 2);
        force_timer = 1'b1;
        count_down_seconds = '0;
        count_down_milliseconds = '0;
        pulse(1'b1, 1'b1);
        chk("t5_expiry_wins", int'(state), 4);
        chk("t5_rounds", int'(round_count), 2);
        force_timer = 1'b0;
        pulse(1'b1, 1'b0);
        repeat (4000) @(negedge clk);
        chk("t5_playing2", int'(state), 2);
        pulse(1'b1, 1'b1);
        chk("t5_start_wins", int'(state), 0);
        chk("t5_rounds_kept", int'(round_count), 2);

        pulse(1'b1, 1'b0);
        repeat (4000) @(negedge clk);
        pulse(1'b0, 1'b1);
        chk("t6_paused", int'(state), 3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_trst", int'(timer_rst), 1);
        chk("t6_rst_en", int'(timer_enable), 0);
        chk("t6_rst_ready", int'(ready_count), 0);
        chk("t6_rst_active", int'(game_active), 0);
        chk("t6_rst_paused", int'(paused), 0);
        chk("t6_rst_over", int'(game_over), 0);
        chk("t6_rst_rounds", int'(round_count), 0);
        @(negedge clk);
        rst = 1'b0;

        @(posedge clk); #2;
        force dut.round_count = 8'd254;
        m_rounds = 254;
        @(posedge clk); #2;
        release dut.round_count;
        @(negedge clk);
        chk("t6_preload", int'(round_count), 254);
        force_timer = 1'b1;
        count_down_seconds = '0;
        count_down_milliseconds = '0;
        pulse(1'b1, 1'b0);
        repeat (4001) @(negedge clk);
        chk("t6_round255_state", int'(state), 4);
        chk("t6_round255", int'(round_count), 255);
        pulse(1'b1, 1'b0);
        repeat (4001) @(negedge clk);
        chk("t6_sat_state", int'(state), 4);
        chk("t6_saturated", int'(round_count), 255);
        force_timer = 1'b0;

        repeat (25000) begin
            start_pulse = ($urandom_range(0, 2499) == 0);
            pause_pulse = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
